mem_responder: RTL and testbench

//   Memory-side responder for the multicycle processor's unified instruction/data memory.

---
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle processor's unified memory.
// Captures a request in IDLE, waits LATENCY cycles and answers with a
// one-cycle Ready pulse. Reads return RD with Ready. Writes commit at the
// edge that ends the Ready cycle.
// Optional feature: define MEMRESP_ALIGN_CHECK_EN to flag misaligned or
// out-of-range addresses with Err. Flagged accesses return RD=0 and drop the write.
module mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] Adr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Ready,
  output logic        Err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] wd_q;
  logic [31:0] mem [DEPTH];

  logic [31:0]   sel_adr;
  logic          sel_we;
  logic [AW-1:0] sel_idx;
  logic          sel_err;
  logic [31:0]   rd_val;

  // In IDLE the live inputs describe the access (LATENCY==1 enters DONE
  // straight from IDLE). Otherwise the captured copies describe it.
  always_comb begin
    sel_adr = (state_q == StIdle) ? Adr : adr_q;
    sel_we  = (state_q == StIdle) ? WE : we_q;
    sel_idx = sel_adr[AW+1:2];
`ifdef MEMRESP_ALIGN_CHECK_EN
    sel_err = (sel_adr[1:0] != 2'b00) || (sel_adr >= 32'(4 * DEPTH));
`else
    sel_err = 1'b0;
`endif
    rd_val  = (sel_we || sel_err) ? 32'h0 : mem[sel_idx];
  end

  // Only the word-index bits of the address take part without the check.
  logic unused_adr;
  assign unused_adr = ^{sel_adr[31:AW+2], sel_adr[1:0]};

  // Control FSM with registered Ready/Err/RD, all valid only in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      wd_q    <= 32'h0;
      Ready   <= 1'b0;
      Err     <= 1'b0;
      RD      <= 32'h0;
    end else begin
      Ready <= 1'b0;
      Err   <= 1'b0;
      RD    <= 32'h0;
      case (state_q)
        StIdle: begin
          if (Req) begin
            adr_q <= Adr;
            we_q  <= WE;
            wd_q  <= WD;
            cnt_q <= LatM1;
            if (LATENCY == 1) begin
              state_q <= StDone;
              Ready   <= 1'b1;
              Err     <= sel_err;
              RD      <= rd_val;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StDone;
            Ready   <= 1'b1;
            Err     <= sel_err;
            RD      <= rd_val;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM write at the end of DONE; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_q == StDone && sel_we && !sel_err) begin
      mem[sel_idx] <= wd_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with LATENCY 1, 2 and 3 share a
// clock and reset. A plain word array per instance is the reference memory.
module tb_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] req;
  logic [NI-1:0] we;
  logic [NI-1:0] ready;
  logic [NI-1:0] err;
  logic [31:0]   adr   [NI];
  logic [31:0]   wd    [NI];
  logic [31:0]   rd    [NI];
  logic [31:0]   model [NI][DEPTH];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .DEPTH  (DEPTH),
      .LATENCY(g + 1)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .Req  (req[g]),
      .WE   (we[g]),
      .Adr  (adr[g]),
      .WD   (wd[g]),
      .RD   (rd[g]),
      .Ready(ready[g]),
      .Err  (err[g])
    );
  end

  function automatic bit exp_err(input logic [31:0] a);
`ifdef MEMRESP_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // One access with Req high for a single cycle; checks latency, data, Err.
  task automatic access(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] data);
    int lat;
    bit e;
    logic [31:0] exp_rd;
    lat = d + 1;
    e = exp_err(a);
    @(negedge clk);
    req[d] = 1'b1; we[d] = wr; adr[d] = a; wd[d] = data;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req[d] = 1'b0; we[d] = $urandom_range(0, 1); adr[d] = $urandom; wd[d] = $urandom;
      end
      if (i < lat) begin
        tests++;
        if (ready[d] !== 1'b0) begin
          failed++;
          $display("FAIL early_ready lat=%0d cyc=%0d got=%b want=0", lat, i, ready[d]);
        end
      end
    end
    exp_rd = (wr || e) ? 32'h0 : model[d][widx(a)];
    tests++;
    if (ready[d] !== 1'b1) begin
      failed++;
      $display("FAIL ready lat=%0d adr=%h got=%b want=1", lat, a, ready[d]);
    end
    tests++;
    if (rd[d] !== exp_rd) begin
      failed++;
      $display("FAIL rd lat=%0d adr=%h wr=%0d got=%h want=%h", lat, a, wr, rd[d], exp_rd);
    end
    tests++;
    if (err[d] !== e) begin
      failed++;
      $display("FAIL err lat=%0d adr=%h got=%b want=%b", lat, a, err[d], e);
    end
    if (wr && !e) model[d][widx(a)] = data;
    we[d] = 1'b0;
    @(negedge clk);
    tests++;
    if (ready[d] !== 1'b0 || rd[d] !== 32'h0 || err[d] !== 1'b0) begin
      failed++;
      $display("FAIL after_done lat=%0d got ready=%b rd=%h err=%b want 0/0/0",
               lat, ready[d], rd[d], err[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < NI; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; adr[d] = 32'h0; wd[d] = 32'h0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < NI; d++) begin
        tests++;
        if (ready[d] !== 1'b0 || rd[d] !== 32'h0 || err[d] !== 1'b0) begin
          failed++;
          $display("FAIL reset_idle inst=%0d got ready=%b rd=%h err=%b want 0/0/0",
                   d, ready[d], rd[d], err[d]);
        end
      end
    end
  endtask

  task automatic test_preload();
    for (int d = 0; d < NI; d++)
      for (int w = 0; w < int'(DEPTH); w++) access(d, 1'b1, 32'(w * 4), $urandom);
  endtask

  task automatic test_write_read();
    for (int d = 0; d < NI; d++) begin
      access(d, 1'b1, 32'h08, 32'hDEADBEEF);
      access(d, 1'b0, 32'h08, 32'h0);
      tests++;
      if (model[d][2] !== 32'hDEADBEEF) begin
        failed++;
        $display("FAIL model_word2 inst=%0d got=%h want=deadbeef", d, model[d][2]);
      end
    end
  endtask

  // Req held high: reads complete every LATENCY+1 cycles.
  task automatic test_back_to_back(input int d);
    int lat;
    logic [31:0] a;
    logic [31:0] exp;
    lat = d + 1;
    a = 32'h0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b0; adr[d] = a;
    exp = model[d][widx(a)];
    for (int i = 1; i <= 8 * (lat + 1); i++) begin
      @(negedge clk);
      tests++;
      if (i % (lat + 1) == lat) begin
        if (ready[d] !== 1'b1 || rd[d] !== exp) begin
          failed++;
          $display("FAIL b2b lat=%0d cyc=%0d got ready=%b rd=%h want 1/%h",
                   lat, i, ready[d], rd[d], exp);
        end
        a = a + 32'd4;
        adr[d] = a;
        exp = model[d][widx(a)];
      end else if (ready[d] !== 1'b0) begin
        failed++;
        $display("FAIL b2b_gap lat=%0d cyc=%0d got ready=%b want 0", lat, i, ready[d]);
      end
    end
    req[d] = 1'b0;
  endtask

  // Reset during WAIT of a write: no Ready and the old word survives.
  task automatic test_reset_in_wait(input int d);
    logic [31:0] a;
    a = 32'h10;
    access(d, 1'b1, a, $urandom);
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b1; adr[d] = a; wd[d] = ~model[d][widx(a)];
    @(negedge clk);
    req[d] = 1'b0; we[d] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (ready[d] !== 1'b0) begin
        failed++;
        $display("FAIL reset_abort lat=%0d cyc=%0d got ready=%b want 0", d + 1, c, ready[d]);
      end
    end
    access(d, 1'b0, a, 32'h0);
  endtask

  task automatic test_align(input int d);
    access(d, 1'b1, 32'h102, 32'hA5A5_0102);
    access(d, 1'b1, 32'h100, 32'h5A5A_0100);
    access(d, 1'b0, 32'h000, 32'h0);
    access(d, 1'b0, 32'h100, 32'h0);
  endtask

  task automatic test_random(input int d);
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else a = $urandom;
      access(d, bit'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog tests=%0d failed=%0d", tests, failed);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    for (int d = 0; d < NI; d++) test_back_to_back(d);
    access(2, 1'b0, 32'h2C, 32'h0);
    for (int d = 1; d < NI; d++) test_reset_in_wait(d);
    for (int d = 0; d < NI; d++) test_align(d);
    for (int d = 0; d < NI; d++) test_random(d);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
